gonx_gather_sequencer: RTL and testbench

//  Downstream consumer of one GON X-bus. Walks a programmed range of column tags, drives the bus

---
 rtl/gonx_gather_sequencer_if.sv | 36 +++
 rtl/gonx_gather_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_gonx_gather_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gonx_gather_sequencer_if.sv
// gonx_gather_sequencer_if
//   Bundles the two streams handled by the gather sequencer:
//     X-bus side : ready_tag ({ready, tag}) out of the sequencer,
//                  enable_value ({enable, value}) back into it.
//     Out side   : out_valid/out_ready handshake with out_tag/out_data.
//   modport master : the sequencer (drives ready_tag and the out stream).
//   modport slave  : the X-bus plus the downstream consumer.
interface gonx_gather_sequencer_if #(
  parameter int ID_LEN    = 5,
  parameter int VALUE_LEN = 32
);
  logic [ID_LEN:0]        ready_tag;
  logic [VALUE_LEN:0]     enable_value;
  logic                   out_valid;
  logic                   out_ready;
  logic [ID_LEN-1:0]      out_tag;
  logic [VALUE_LEN-1:0]   out_data;

  modport master (
    output ready_tag,
    input  enable_value,
    output out_valid,
    input  out_ready,
    output out_tag,
    output out_data
  );

  modport slave (
    input  ready_tag,
    output enable_value,
    input  out_valid,
    output out_ready,
    input  out_tag,
    input  out_data
  );
endinterface

// File: rtl/gonx_gather_sequencer.sv
// gonx_gather_sequencer
//   Consumer of one GON X-bus. Walks tag_base .. tag_base+tag_count-1 (mod 2^ID_LEN),
//   presents each tag on ready_tag, and captures the same-cycle enable_value response.
//   Accepted {tag,value} pairs go into a small FIFO that streams out over valid/ready.
//   A tag is only offered while the FIFO has room, which back-pressures the X-bus.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             launch pulse, sampled only in IDLE together with tag_base/tag_count
//   tag_base          first tag of the pass
//   tag_count         number of tags in the pass (0 .. 2^ID_LEN)
//   busy              high in ISSUE and DRAIN
//   done              one-cycle pulse at end of pass
//   timeout_err       sticky stall flag
//   bus (master)      ready_tag / enable_value X-bus pair and out_valid/out_ready/out_tag/out_data
//
// Build option
//   GONX_GATHER_TIMEOUT_EN : when defined, a tag that stalls TIMEOUT cycles is skipped and
//   timeout_err is set until reset or the next start. When undefined, every tag waits
//   indefinitely, no stall counter exists and timeout_err is tied low.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start
// ISSUE  | presenting tags on the X-bus while the FIFO has room
// DRAIN  | all tags handled; waiting for the FIFO to empty
module gonx_gather_sequencer #(
  parameter int ID_LEN     = 5,
  parameter int VALUE_LEN  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ID_LEN-1:0]     tag_base,
  input  logic [ID_LEN:0]       tag_count,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  gonx_gather_sequencer_if.master bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ID_LEN + VALUE_LEN;
  localparam int REM_W   = ID_LEN + 1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
    $error("gonx_gather_sequencer: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_LEN-1:0]   cur_tag_q, cur_tag_d;
  logic [REM_W-1:0]    remaining_q, remaining_d;
  logic                done_q, done_d;
  logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                full, empty, ready, enable, accept, skip, advance, pop;
  logic [ENTRY_W-1:0]  head;

  assign full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  // ready depends only on registers, so the X-bus may answer combinationally.
  assign ready  = (state_q == ST_ISSUE) && !full;
  assign enable = bus.enable_value[VALUE_LEN];
  assign accept = ready && enable;
  assign pop    = !empty && bus.out_ready;

`ifdef GONX_GATHER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic                timeout_err_q, timeout_err_d;
  // This stalled cycle is the TIMEOUT-th one for the current tag: give up on it.
  assign skip        = ready && !enable && (stall_q == STALL_W'(TIMEOUT - 1));
  assign timeout_err = timeout_err_q;
`else
  assign skip        = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign advance = accept || skip;

  always_comb begin
    state_d     = state_q;
    cur_tag_d   = cur_tag_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
`ifdef GONX_GATHER_TIMEOUT_EN
    stall_d       = stall_q;
    timeout_err_d = timeout_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_tag_d   = tag_base;
          remaining_d = tag_count;
`ifdef GONX_GATHER_TIMEOUT_EN
          stall_d       = '0;
          timeout_err_d = 1'b0;
`endif
          if (tag_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (advance) begin
          cur_tag_d   = cur_tag_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == REM_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
`ifdef GONX_GATHER_TIMEOUT_EN
        if (advance) begin
          stall_d = '0;
        end else if (ready) begin
          stall_d = stall_q + 1'b1;
        end
        if (skip) begin
          timeout_err_d = 1'b1;
        end
`endif
      end
      ST_DRAIN: begin
        // No pushes happen here, so once empty the FIFO stays empty while done is high.
        if (empty) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      mem_d[wr_ptr_q] = {cur_tag_q, bus.enable_value[VALUE_LEN-1:0]};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cur_tag_q   <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef GONX_GATHER_TIMEOUT_EN
      stall_q       <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_tag_q   <= cur_tag_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
`ifdef GONX_GATHER_TIMEOUT_EN
      stall_q       <= stall_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign bus.ready_tag = {ready, ((state_q == ST_ISSUE) ? cur_tag_q : {ID_LEN{1'b0}})};
  assign bus.out_valid = !empty;
  assign bus.out_tag   = empty ? '0 : head[ENTRY_W-1:VALUE_LEN];
  assign bus.out_data  = empty ? '0 : head[VALUE_LEN-1:0];

endmodule

// File: tb/tb_gonx_gather_sequencer.sv
module tb_gonx_gather_sequencer;
  localparam int ID_LEN     = 5;
  localparam int VALUE_LEN  = 32;
  localparam int FIFO_DEPTH = 4;
`ifdef GONX_GATHER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [4:0]        tag_base = '0;
  logic [5:0]        tag_count = '0;
  logic              out_ready = 1'b0;
  logic              busy, done, timeout_err;

  gonx_gather_sequencer_if #(.ID_LEN(ID_LEN), .VALUE_LEN(VALUE_LEN)) bus ();

  gonx_gather_sequencer #(
    .ID_LEN(ID_LEN), .VALUE_LEN(VALUE_LEN), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tag_base(tag_base), .tag_count(tag_count),
    .busy(busy), .done(done), .timeout_err(timeout_err), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // X-bus model: answers every offered tag, except the first hold_n offers of hold_tag.
  logic [4:0] hold_tag = '0;
  int         hold_n   = 0;
  int         hold_seen = 0;
  logic       rdy, en;
  logic [4:0] tg;

  function automatic logic [31:0] val_of(input logic [4:0] t);
    return 32'hA5C3_0000 | {19'd0, t, 3'b101, t};
  endfunction

  always_comb begin
    rdy = bus.ready_tag[ID_LEN];
    tg  = bus.ready_tag[ID_LEN-1:0];
    en  = rdy && !((tg == hold_tag) && (hold_seen < hold_n));
    bus.enable_value = {en, val_of(tg)};
  end
  assign bus.out_ready = out_ready;

  always @(posedge clk) begin
    if (start) hold_seen <= 0;
    else if (rdy && (tg == hold_tag) && !en) hold_seen <= hold_seen + 1;
  end

  // Event log, sampled mid-cycle.
  logic [4:0]  pres_q[$];
  int          pres_cyc[$];
  logic [4:0]  acc_q[$];
  logic [4:0]  pop_tag[$];
  logic [31:0] pop_dat[$];
  int          done_cnt = 0;
  int          viol = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rdy) begin
      pres_q.push_back(tg);
      pres_cyc.push_back(cyc);
    end
    if (rdy && en) acc_q.push_back(tg);
    if (bus.out_valid && out_ready) begin
      pop_tag.push_back(bus.out_tag);
      pop_dat.push_back(bus.out_data);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (done && bus.out_valid) viol <= viol + 1;
  end

  task automatic start_pass(input logic [4:0] b, input logic [5:0] c);
    @(posedge clk); #1;
    start = 1'b1; tag_base = b; tag_count = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_idle();
    #12;
    n_tests++;
    if ({busy, done, timeout_err, bus.ready_tag, bus.out_valid, bus.out_tag, bus.out_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b terr=%b rt=%h ov=%b ot=%h od=%h, want all 0",
               busy, done, timeout_err, bus.ready_tag, bus.out_valid, bus.out_tag, bus.out_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || bus.ready_tag !== '0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b ready_tag=%h, want 0/0", busy, bus.ready_tag);
    end
  endtask

  task automatic test_stream(input string nm, input logic [4:0] b, input logic [5:0] c);
    int p0 = pres_q.size();
    int o0 = pop_tag.size();
    int d0 = done_cnt;
    int v0 = viol;
    bit ok;
    logic [4:0] e;
    hold_n = 0; out_ready = 1'b1;
    start_pass(b, c);
    wait_idle(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s_timeout: pass never finished", nm); end
    n_tests++;
    if (pres_q.size() - p0 != int'(c)) begin
      n_fail++; $display("FAIL %s_offers: got %0d tags offered, want %0d", nm, pres_q.size() - p0, c);
    end
    n_tests++;
    if (pop_tag.size() - o0 != int'(c)) begin
      n_fail++; $display("FAIL %s_pops: got %0d outputs, want %0d", nm, pop_tag.size() - o0, c);
    end
    for (int i = 0; i < int'(c); i++) begin
      e = b + 5'(i);
      if (p0 + i < pres_q.size()) begin
        n_tests++;
        if (pres_q[p0+i] !== e || pres_cyc[p0+i] != pres_cyc[p0] + i) begin
          n_fail++;
          $display("FAIL %s_tag%0d: got tag %0d at cycle %0d, want tag %0d at cycle %0d",
                   nm, i, pres_q[p0+i], pres_cyc[p0+i], e, pres_cyc[p0] + i);
        end
      end
      if (o0 + i < pop_tag.size()) begin
        n_tests++;
        if (pop_tag[o0+i] !== e || pop_dat[o0+i] !== val_of(e)) begin
          n_fail++;
          $display("FAIL %s_out%0d: got %0d/%h, want %0d/%h", nm, i, pop_tag[o0+i], pop_dat[o0+i], e, val_of(e));
        end
      end
    end
    n_tests++;
    if (done_cnt - d0 != 1 || viol != v0) begin
      n_fail++; $display("FAIL %s_done: got %0d pulses (%0d with out_valid), want 1 (0)", nm, done_cnt - d0, viol - v0);
    end
  endtask

  task automatic test_backpressure();
    int a0 = acc_q.size();
    int o0 = pop_tag.size();
    int d0 = done_cnt;
    bit ok;
    logic [4:0] e;
    hold_n = 0; out_ready = 1'b0;
    start_pass(5'd10, 6'd6);
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (acc_q.size() - a0 != 4 || rdy !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bp_full: got pushes=%0d ready=%b busy=%b, want 4/0/1", acc_q.size() - a0, rdy, busy);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd10 || bus.out_data !== val_of(5'd10)) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b %0d/%h, want 1 10/%h", i, bus.out_valid, bus.out_tag, bus.out_data, val_of(5'd10));
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle(ok);
    n_tests++;
    if (!ok || pop_tag.size() - o0 != 6 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL bp_resume: got ok=%b outputs=%0d done=%0d, want 1/6/1", ok, pop_tag.size() - o0, done_cnt - d0);
    end
    for (int i = 0; i < 6 && o0 + i < pop_tag.size(); i++) begin
      e = 5'd10 + 5'(i);
      n_tests++;
      if (pop_tag[o0+i] !== e || pop_dat[o0+i] !== val_of(e)) begin
        n_fail++; $display("FAIL bp_out%0d: got %0d/%h, want %0d/%h", i, pop_tag[o0+i], pop_dat[o0+i], e, val_of(e));
      end
    end
  endtask

  task automatic test_stall();
    int p0 = pres_q.size();
    int a0 = acc_q.size();
    int o0 = pop_tag.size();
    int n7 = 0;
    bit ok;
    out_ready = 1'b1; hold_tag = 5'd7; hold_n = 5;
    start_pass(5'd7, 6'd2);
    wait_idle(ok);
    hold_n = 0;
    for (int i = p0; i < pres_q.size(); i++) if (pres_q[i] == 5'd7) n7++;
    n_tests++;
    if (!ok || n7 != 6) begin n_fail++; $display("FAIL stall_hold: got tag7 offered %0d cycles (ok=%b), want 6", n7, ok); end
    n_tests++;
    if (acc_q.size() - a0 != 2 || pop_tag.size() - o0 != 2) begin
      n_fail++; $display("FAIL stall_count: got %0d pushes %0d outputs, want 2/2", acc_q.size() - a0, pop_tag.size() - o0);
    end else begin
      n_tests++;
      if (pop_tag[o0] !== 5'd7 || pop_tag[o0+1] !== 5'd8 || pop_dat[o0] !== val_of(5'd7)) begin
        n_fail++; $display("FAIL stall_order: got %0d,%0d, want 7,8", pop_tag[o0], pop_tag[o0+1]);
      end
    end
    n_tests++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL stall_terr: got %b, want 0", timeout_err); end
  endtask

  task automatic test_zero_count();
    @(posedge clk); #1;
    start = 1'b1; tag_base = 5'd9; tag_count = 6'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || rdy !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: got done=%b busy=%b ready=%b, want 1/0/0", done, busy, rdy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL zero_pulse: got done=%b terr=%b, want 0/0", done, timeout_err);
    end
  endtask

`ifdef GONX_GATHER_TIMEOUT_EN
  task automatic test_timeout();
    int p0 = pres_q.size();
    int a0 = acc_q.size();
    int o0 = pop_tag.size();
    int d0 = done_cnt;
    int n3 = 0;
    bit ok;
    out_ready = 1'b1; hold_tag = 5'd3; hold_n = 1000;
    start_pass(5'd3, 6'd2);
    wait_idle(ok);
    hold_n = 0;
    for (int i = p0; i < pres_q.size(); i++) if (pres_q[i] == 5'd3) n3++;
    n_tests++;
    if (!ok || n3 != 8) begin n_fail++; $display("FAIL tmo_stalls: got tag3 offered %0d cycles (ok=%b), want 8", n3, ok); end
    n_tests++;
    if (acc_q.size() - a0 != 1 || pop_tag.size() - o0 != 1 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL tmo_count: got %0d pushes %0d outputs %0d done, want 1/1/1",
                         acc_q.size() - a0, pop_tag.size() - o0, done_cnt - d0);
    end else begin
      n_tests++;
      if (pop_tag[o0] !== 5'd4) begin n_fail++; $display("FAIL tmo_tag: got %0d, want 4", pop_tag[o0]); end
    end
    n_tests++;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b, want 1", timeout_err); end
  endtask
`endif

  task automatic test_reset_mid_drain();
    out_ready = 1'b0; hold_n = 0;
    start_pass(5'd20, 6'd3);
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || rdy !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_tag !== 5'd20) begin
      n_fail++; $display("FAIL rstd_pre: got busy=%b ready=%b valid=%b tag=%0d, want 1/0/1/20", busy, rdy, bus.out_valid, bus.out_tag);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, timeout_err, bus.ready_tag, bus.out_valid, bus.out_tag, bus.out_data} !== '0) begin
      n_fail++;
      $display("FAIL rstd_async: got busy=%b done=%b terr=%b rt=%h ov=%b ot=%h od=%h, want all 0",
               busy, done, timeout_err, bus.ready_tag, bus.out_valid, bus.out_tag, bus.out_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstd_after: got valid=%b busy=%b, want 0/0", bus.out_valid, busy);
    end
  endtask

  initial begin
    test_reset_idle();
    test_stream("basic", 5'd2, 6'd3);
    test_stream("wrap", 5'd30, 6'd4);
    test_backpressure();
    test_stall();
`ifdef GONX_GATHER_TIMEOUT_EN
    test_timeout();
`endif
    test_zero_count();
    test_stream("full_range", 5'd17, 6'd32);
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
